flappy_engine: RTL and testbench

Parametrised game-state engine for the Flappy Bird core: bird physics, a scrolling pipe queue, collision, scoring and a restart path. It replaces the fixed-size per-clock engine with one advanced by a frame strobe, with latched button presses, configurable widths and pipe count, and a score counter. It sits between the input conditioner, the RNG and the renderer, and exposes its full state to the renderer each frame.

---
 rtl/flappy_engine.sv | 138 +++++++++++++
 tb/tb_flappy_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_engine.sv
// Frame-strobed Flappy Bird game-state engine: bird physics, pipe queue,
// collision, scoring and restart, all advanced only on tick.
module flappy_engine #(
    parameter int NUM_PIPES  = 5,
    parameter int Y_W        = 10,
    parameter int X_W        = 8,
    parameter int SCORE_W    = 8,
    parameter int SKY        = 480,
    parameter int PIPE_GAP   = 240,
    parameter int PIPE_WIDTH = 60,
    parameter int PIPE_ALLOW = 45,
    parameter int BIRD_SZ    = 15,
    parameter int JMP        = 3,
    parameter int GRAV       = 1,
    parameter int START_Y    = 200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       press,
    input  logic [31:0]                rng,
    output logic [1:0]                 state,
    output logic signed [Y_W-1:0]      bird_y,
    output logic [X_W-1:0]             scroll_x,
    output logic [NUM_PIPES*Y_W-1:0]   pipe_c,
    output logic [SCORE_W-1:0]         score,
    output logic                       score_pulse,
    output logic                       die_pulse
);
    // state | meaning
    // IDLE  | waiting for the first flap, nothing moves
    // PLAY  | physics, scrolling, collision and scoring run each tick
    // DEAD  | frozen until a flap returns everything to reset values
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_t;

    localparam int HIT_X = PIPE_WIDTH + 2*BIRD_SZ;

    state_t                 st;
    logic signed [Y_W-1:0]  vel;
    logic [Y_W-1:0]         slot [NUM_PIPES];
    logic                   press_q;
    logic                   flap;
    logic                   flap_now;
    logic                   dead;
    logic                   wrap;
    logic                   score_hit;
    logic [X_W-1:0]         scroll_nx;
    logic [Y_W-1:0]         spawn;
    logic signed [31:0]     y_ext, c0_ext, low, high;

    // An edge coinciding with the tick counts for that tick.
    assign flap_now = flap | (press & ~press_q);
    assign spawn    = Y_W'((rng % 32'(SKY - 2*PIPE_ALLOW)) + 32'(PIPE_ALLOW));
    assign state    = st;

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
        assign pipe_c[g*Y_W +: Y_W] = slot[g];
    end

    // Pipe centres are unsigned heights; only the bird can go negative.
    always_comb begin
        y_ext  = 32'(bird_y);
        c0_ext = signed'(32'(slot[0]));
        if (slot[0] != '0 && int'(scroll_x) < HIT_X) begin
            low  = c0_ext - PIPE_ALLOW;
            high = c0_ext + PIPE_ALLOW;
        end else begin
            low  = 0;
            high = SKY;
        end
        dead      = (y_ext - BIRD_SZ < low) || (y_ext + BIRD_SZ >= high);
        wrap      = !(scroll_x < X_W'(PIPE_GAP - 1));
        scroll_nx = wrap ? '0 : scroll_x + 1'b1;
        score_hit = !wrap && (scroll_nx == X_W'(HIT_X)) && (slot[0] != '0)
                    && (score != '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            bird_y      <= Y_W'(START_Y);
            vel         <= '0;
            scroll_x    <= '0;
            score       <= '0;
            score_pulse <= 1'b0;
            die_pulse   <= 1'b0;
            flap        <= 1'b0;
            press_q     <= 1'b1;
            for (int i = 0; i < NUM_PIPES; i++) slot[i] <= '0;
        end else begin
            press_q     <= press;
            score_pulse <= 1'b0;
            die_pulse   <= 1'b0;
            if (!tick) begin
                flap <= flap_now;
            end else begin
                flap <= 1'b0;
                case (st)
                    IDLE: begin
                        if (flap_now) begin
                            st  <= PLAY;
                            vel <= Y_W'(JMP);
                        end
                    end
                    PLAY: begin
                        if (dead) begin
                            st        <= DEAD;
                            die_pulse <= 1'b1;
                        end else begin
                            bird_y   <= bird_y + vel;
                            vel      <= flap_now ? Y_W'(JMP) : vel - Y_W'(GRAV);
                            scroll_x <= scroll_nx;
                            if (wrap) begin
                                for (int i = 0; i < NUM_PIPES-1; i++) slot[i] <= slot[i+1];
                                slot[NUM_PIPES-1] <= spawn;
                            end
                            if (score_hit) begin
                                score       <= score + 1'b1;
                                score_pulse <= 1'b1;
                            end
                        end
                    end
                    DEAD: begin
                        if (flap_now) begin
                            st       <= IDLE;
                            bird_y   <= Y_W'(START_Y);
                            vel      <= '0;
                            scroll_x <= '0;
                            score    <= '0;
                            for (int i = 0; i < NUM_PIPES; i++) slot[i] <= '0;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_flappy_engine.sv
// Bench for flappy_engine: vector table, directed corner sequences and a
// randomized run, all checked against a frame-level behavioural model.
module tb_flappy_engine;
    localparam int NP = 5;
    localparam int YW = 10;
    localparam int XW = 8;
    localparam int SW = 8;

    logic                  clk = 1'b0;
    logic                  rst, tick, press;
    logic [31:0]           rng;
    logic [1:0]            state;
    logic signed [YW-1:0]  bird_y;
    logic [XW-1:0]         scroll_x;
    logic [NP*YW-1:0]      pipe_c;
    logic [SW-1:0]         score;
    logic                  score_pulse, die_pulse;

    always #5 clk = ~clk;

    flappy_engine dut (
        .clk(clk), .rst(rst), .tick(tick), .press(press), .rng(rng),
        .state(state), .bird_y(bird_y), .scroll_x(scroll_x), .pipe_c(pipe_c),
        .score(score), .score_pulse(score_pulse), .die_pulse(die_pulse)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: integer game state stepped once per clk.
    int ms, my, mv, mscroll, mscore;
    int mslot [NP];
    bit mflap, mpq, msp, mdp;

    function automatic int wrapy(input int x);
        int r;
        r = (x + 512) % 1024;
        if (r < 0) r += 1024;
        return r - 512;
    endfunction

    task automatic model_game_reset();
        ms = 0; my = 200; mv = 0; mscroll = 0; mscore = 0;
        mflap = 0; msp = 0; mdp = 0;
        for (int i = 0; i < NP; i++) mslot[i] = 0;
    endtask

    task automatic model_reset();
        model_game_reset();
        mpq = 1;
    endtask

    task automatic model_step(input bit tk, input bit pr, input logic [31:0] r);
        bit e, f, hit;
        int low, high;
        msp = 0; mdp = 0;
        e = pr && !mpq;
        mpq = pr;
        if (!tk) begin
            mflap = mflap | e;
            return;
        end
        f = mflap | e;
        mflap = 0;
        case (ms)
            0: if (f) begin ms = 1; mv = 3; end
            1: begin
                if (mslot[0] != 0 && mscroll < 90) begin
                    low = mslot[0] - 45; high = mslot[0] + 45;
                end else begin
                    low = 0; high = 480;
                end
                hit = (my - 15 < low) || (my + 15 >= high);
                if (hit) begin
                    ms = 2; mdp = 1;
                end else begin
                    my = wrapy(my + mv);
                    mv = f ? 3 : wrapy(mv - 1);
                    if (mscroll < 239) mscroll++;
                    else begin
                        mscroll = 0;
                        for (int i = 0; i < NP-1; i++) mslot[i] = mslot[i+1];
                        mslot[NP-1] = int'(((r % 32'd390) + 32'd45) & 32'h3FF);
                    end
                    if (mscroll == 90 && mslot[0] != 0 && mscore < 255) begin
                        mscore++; msp = 1;
                    end
                end
            end
            default: if (f) model_game_reset();
        endcase
    endtask

    function automatic int slot_of(input int i);
        return int'(pipe_c[i*YW +: YW]);
    endfunction

    task automatic check_all();
        chk("state", int'(state), ms);
        chk("bird_y", int'(bird_y), my);
        chk("scroll_x", int'(scroll_x), mscroll);
        chk("score", int'(score), mscore);
        chk("score_pulse", int'(score_pulse), int'(msp));
        chk("die_pulse", int'(die_pulse), int'(mdp));
        for (int i = 0; i < NP; i++) chk($sformatf("slot%0d", i), slot_of(i), mslot[i]);
    endtask

    task automatic step(input bit tk, input bit pr);
        tick = tk; press = pr;
        @(posedge clk);
        model_step(tk, pr, rng);
        #1;
        check_all();
    endtask

    task automatic do_reset(input bit pr);
        press = pr; tick = 0; rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 0;
    endtask

    typedef struct {bit tk; bit pr; int st; int y; int sx;} vec_t;
    vec_t tbl [18];

    initial begin
        bit seen, was_play;
        int play_ticks, y_dead;

        tbl[0]  = '{0, 0, 0, 200, 0};
        tbl[1]  = '{0, 1, 0, 200, 0};
        tbl[2]  = '{1, 0, 1, 200, 0};
        tbl[3]  = '{1, 0, 1, 203, 1};
        tbl[4]  = '{1, 0, 1, 205, 2};
        tbl[5]  = '{1, 0, 1, 206, 3};
        tbl[6]  = '{0, 1, 1, 206, 3};
        tbl[7]  = '{0, 0, 1, 206, 3};
        tbl[8]  = '{0, 1, 1, 206, 3};
        tbl[9]  = '{1, 0, 1, 206, 4};
        tbl[10] = '{1, 0, 1, 209, 5};
        tbl[11] = '{1, 0, 1, 211, 6};
        tbl[12] = '{1, 0, 1, 212, 7};
        tbl[13] = '{1, 0, 1, 212, 8};
        tbl[14] = '{1, 0, 1, 211, 9};
        tbl[15] = '{1, 1, 1, 209, 10};
        tbl[16] = '{1, 1, 1, 212, 11};
        tbl[17] = '{1, 0, 1, 214, 12};

        rng = 32'h1234_5678;
        do_reset(0);
        chk("reset_state", int'(state), 0);
        chk("reset_y", int'(bird_y), 200);

        // Ticks without any press leave the game idle.
        for (int i = 0; i < 100; i++) begin
            step(1, 0);
            chk("idle_state", int'(state), 0);
            chk("idle_y", int'(bird_y), 200);
        end

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].tk, tbl[i].pr);
            chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("tbl%0d_y", i), int'(bird_y), tbl[i].y);
            chk($sformatf("tbl%0d_scroll", i), int'(scroll_x), tbl[i].sx);
        end

        // Free fall to the floor.
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1, 0);
            if (die_pulse) seen = 1;
        end
        chk("die_seen", int'(seen), 1);
        chk("dead_state", int'(state), 2);
        chk("dead_below_floor", int'(bird_y < 10'sd15), 1);
        y_dead = my;
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("dead_frozen_y", int'(bird_y), y_dead);
        chk("dead_pulse_gone", int'(die_pulse), 0);

        // Restart needs a flap; a second flap starts play.
        step(0, 1);
        step(1, 0);
        chk("restart_state", int'(state), 0);
        chk("restart_y", int'(bird_y), 200);
        chk("restart_score", int'(score), 0);
        chk("restart_pipes", int'(pipe_c == '0), 1);
        step(1, 0);
        chk("restart_no_play", int'(state), 0);
        step(0, 1);
        step(1, 0);
        chk("replay_state", int'(state), 1);

        // Press held through reset release is not an edge.
        do_reset(1);
        step(1, 1);
        chk("held_press_idle", int'(state), 0);
        step(1, 0);

        // Hover near y=45 with rng=0 and pass the first pipe.
        rng = 0;
        step(0, 1);
        step(1, 0);
        play_ticks = 0;
        for (int i = 0; i < 4000 && play_ticks < 1290 && ms != 2; i++) begin
            if (my + mv < 45) step(0, 1);
            was_play = (ms == 1);
            step(1, 0);
            if (was_play) begin
                play_ticks++;
                if (play_ticks == 240) begin
                    chk("spawn_slot4", slot_of(4), 45);
                    chk("spawn_scroll", int'(scroll_x), 0);
                end
                if (play_ticks == 1200) chk("queue_slot0", slot_of(0), 45);
                if (play_ticks == 1289) chk("score_before", int'(score), 0);
                if (play_ticks == 1290) begin
                    chk("score_after", int'(score), 1);
                    chk("score_pulse_hi", int'(score_pulse), 1);
                    chk("score_scroll", int'(scroll_x), 90);
                end
            end
        end
        chk("hover_reached", play_ticks, 1290);
        step(0, 0);
        chk("score_pulse_lo", int'(score_pulse), 0);

        // Randomized run with occasional asynchronous resets.
        do_reset(0);
        for (int i = 0; i < 6000; i++) begin
            rng = $urandom;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1;
                #2;
                model_reset();
                check_all();
                rst = 0;
            end
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
